// File: rtl/vedic_seq_mul16.sv
// Sequential 16x16 unsigned multiplier driving an external 8x8 core over four steps.
// Optional macro VSM_ZERO_SKIP_EN: zero operands bypass the multiply steps.
module vedic_seq_mul16 #(
    parameter int MAC_EN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        acc_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_m
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on valid, and valid/data hold until the transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [31:0] acc;
    logic        in_ready_r;
    logic        out_valid_r;

    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [31:0] addend;
    logic        keep_acc;
    logic        skip;

    assign keep_acc = (MAC_EN != 0) && !acc_clr;

`ifdef VSM_ZERO_SKIP_EN
    assign skip = (a == 16'd0) || (b == 16'd0);
`else
    assign skip = 1'b0;
`endif

    // Byte-pair selection and partial-product alignment for the current step.
    always_comb begin
        sel_a  = 8'd0;
        sel_b  = 8'd0;
        addend = 32'd0;
        if (state == MUL) begin
            case (step)
                2'd0: begin
                    sel_a  = a_r[7:0];
                    sel_b  = b_r[7:0];
                    addend = {16'd0, mul_m};
                end
                2'd1: begin
                    sel_a  = a_r[7:0];
                    sel_b  = b_r[15:8];
                    addend = {8'd0, mul_m, 8'd0};
                end
                2'd2: begin
                    sel_a  = a_r[15:8];
                    sel_b  = b_r[7:0];
                    addend = {8'd0, mul_m, 8'd0};
                end
                default: begin
                    sel_a  = a_r[15:8];
                    sel_b  = b_r[15:8];
                    addend = {mul_m, 16'd0};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= 2'd0;
            a_r         <= 16'd0;
            b_r         <= 16'd0;
            acc         <= 32'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        step       <= 2'd0;
                        in_ready_r <= 1'b0;
                        if (!keep_acc) begin
                            acc <= 32'd0;
                        end
                        if (skip) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc  <= acc + addend;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign p         = acc;
    assign mul_a     = sel_a;
    assign mul_b     = sel_b;

endmodule

// File: tb/tb_vedic_seq_mul16.sv
// Randomized bench for vedic_seq_mul16: plain (MAC_EN=0) and accumulating (MAC_EN=1) instances.
module tb_vedic_seq_mul16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, acc_clr, out_ready, sel;
    logic [15:0] a, b;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [31:0] p0, p1;
    logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
    logic [15:0] mul_m0, mul_m1;
    logic        in_valid0, in_valid1;

    // Behavioural 8x8 cores
    assign mul_m0 = {8'd0, mul_a0} * {8'd0, mul_b0};
    assign mul_m1 = {8'd0, mul_a1} * {8'd0, mul_b1};

    assign in_valid0 = in_valid && !sel;
    assign in_valid1 = in_valid && sel;

    vedic_seq_mul16 #(.MAC_EN(0)) u_mul0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid0), .out_ready(out_ready),
        .p(p0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_m(mul_m0)
    );

    vedic_seq_mul16 #(.MAC_EN(1)) u_mul1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid1), .out_ready(out_ready),
        .p(p1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_m(mul_m1)
    );

    logic        in_ready_s, out_valid_s;
    logic [31:0] p_s;
    logic [7:0]  mul_a_s, mul_b_s;
    assign in_ready_s  = sel ? in_ready1  : in_ready0;
    assign out_valid_s = sel ? out_valid1 : out_valid0;
    assign p_s         = sel ? p1 : p0;
    assign mul_a_s     = sel ? mul_a1 : mul_a0;
    assign mul_b_s     = sel ? mul_b1 : mul_b0;

    // Scoreboard and reference state
    logic [31:0] exp_q[$];
    logic [31:0] acc_m[2];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Starts and ends at a falling edge with the selected instance idle.
    task automatic run_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                          input logic clr, input int hold, input logic chain);
        logic [31:0] prod, exp_p, p_hold;
        logic [7:0]  ea[4];
        logic [7:0]  eb[4];
        int lat, edges;
        sel = s;
        check("in_ready_idle", {31'd0, in_ready_s}, 32'd1);
        prod  = {16'd0, av} * {16'd0, bv};
        exp_p = (s && !clr) ? acc_m[1] + prod : prod;
        acc_m[s] = exp_p;
        exp_q.push_back(exp_p);
        lat = 4;
`ifdef VSM_ZERO_SKIP_EN
        if (av == 16'd0 || bv == 16'd0) lat = 0;
`endif
        ea = '{av[7:0], av[7:0], av[15:8], av[15:8]};
        eb = '{bv[7:0], bv[15:8], bv[7:0], bv[15:8]};
        a = av; b = bv; acc_clr = clr; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        if (!chain) in_valid = 1'b0;
        edges = 0;
        while (!out_valid_s && edges < 20) begin
            check("in_ready_busy", {31'd0, in_ready_s}, 32'd0);
            if (edges < 4) begin
                check("mul_a_step", {24'd0, mul_a_s}, {24'd0, ea[edges]});
                check("mul_b_step", {24'd0, mul_b_s}, {24'd0, eb[edges]});
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        // edges counts rising edges after the accept edge until out_valid is seen
        check("latency", edges, lat);
        check("p", p_s, exp_q.pop_front());
        check("core_in_done", {16'd0, mul_a_s, mul_b_s}, 32'd0);
        check("in_ready_done", {31'd0, in_ready_s}, 32'd0);
        p_hold = p_s;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("out_valid_hold", {31'd0, out_valid_s}, 32'd1);
            check("p_hold", p_s, p_hold);
            check("in_ready_hold", {31'd0, in_ready_s}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after", {31'd0, out_valid_s}, 32'd0);
        check("in_ready_after", {31'd0, in_ready_s}, 32'd1);
        check("core_in_idle", {16'd0, mul_a_s, mul_b_s}, 32'd0);
    endtask

    task automatic reset_mid_op();
        sel = 1'b0;
        a = 16'hABCD; b = 16'h1234; acc_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_step2_mul_a", {24'd0, mul_a_s}, 32'h0000_00AB);
        check("rst_step2_mul_b", {24'd0, mul_b_s}, 32'h0000_0034);
        rst_n = 1'b0;
        #1;
        acc_m[0] = 32'd0;
        acc_m[1] = 32'd0;
        check("rst_mid_out_valid", {31'd0, out_valid_s}, 32'd0);
        check("rst_mid_p", p_s, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready_s}, 32'd1);
        check("rst_mid_core_in", {16'd0, mul_a_s, mul_b_s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; a = 16'd0; b = 16'd0;
        acc_clr = 1'b0; out_ready = 1'b0; sel = 1'b0;
        acc_m[0] = 32'd0;
        acc_m[1] = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready0", {31'd0, in_ready0}, 32'd1);
        check("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
        check("rst_p0", p0, 32'd0);
        check("rst_core_in0", {16'd0, mul_a0, mul_b0}, 32'd0);
        check("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
        check("rst_p1", p1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 16'h00FF, 16'h00FF, 1'b0, 0, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b1);
        run_op(1'b0, 16'h1234, 16'h5678, 1'b0, 0, 1'b1);
        in_valid = 1'b0;
        run_op(1'b0, 16'h0010, 16'h0010, 1'b0, 3, 1'b0);
        reset_mid_op();
        run_op(1'b0, 16'h0003, 16'h0005, 1'b0, 0, 1'b0);

        run_op(1'b1, 16'h0002, 16'h0003, 1'b1, 0, 1'b0);
        run_op(1'b1, 16'h0004, 16'h0005, 1'b0, 0, 1'b0);
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1, 1'b0);
        run_op(1'b1, 16'h0001, 16'h0001, 1'b1, 0, 1'b0);

        run_op(1'b0, 16'h0000, 16'hABCD, 1'b0, 1, 1'b0);
        run_op(1'b1, 16'h5555, 16'h0000, 1'b0, 0, 1'b0);

        repeat (40) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            run_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
